cs_address_sequencer: RTL and testbench

CS_ADDRESS_SEQUENCER -- requirements
Module: cs_address_sequencer

---
 rtl/cs_address_sequencer_if.sv | 47 ++++
 rtl/cs_address_sequencer.sv | 98 +++++++++
 tb/tb_cs_address_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cs_address_sequencer_if.sv
// Microinstruction-field, memory-handshake and status bundle between the
// control store / datapath and the control-store address sequencer.
interface cs_address_sequencer_if #(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_IR          = 32
);
  logic [DATAWIDTH_CONDITION-1:0]   CS_ADDRESS_SEQUENCER_Condition_InBus;
  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_JumpAddress_InBus;
  logic [DATAWIDTH_IR-1:0]          CS_ADDRESS_SEQUENCER_IR_InBus;
  logic                             CS_ADDRESS_SEQUENCER_RD_In;
  logic                             CS_ADDRESS_SEQUENCER_WR_In;
  logic                             CS_ADDRESS_SEQUENCER_MemReady_In;
  logic                             CS_ADDRESS_SEQUENCER_FlagEn_In;
  logic [3:0]                       CS_ADDRESS_SEQUENCER_NZVC_InBus;
  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus;
  logic [3:0]                       CS_ADDRESS_SEQUENCER_PSR_OutBus;
  logic                             CS_ADDRESS_SEQUENCER_Hold_Out;

  modport master (
    output CS_ADDRESS_SEQUENCER_Condition_InBus,
    output CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
    output CS_ADDRESS_SEQUENCER_IR_InBus,
    output CS_ADDRESS_SEQUENCER_RD_In,
    output CS_ADDRESS_SEQUENCER_WR_In,
    output CS_ADDRESS_SEQUENCER_MemReady_In,
    output CS_ADDRESS_SEQUENCER_FlagEn_In,
    output CS_ADDRESS_SEQUENCER_NZVC_InBus,
    input  CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
    input  CS_ADDRESS_SEQUENCER_PSR_OutBus,
    input  CS_ADDRESS_SEQUENCER_Hold_Out
  );

  modport slave (
    input  CS_ADDRESS_SEQUENCER_Condition_InBus,
    input  CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
    input  CS_ADDRESS_SEQUENCER_IR_InBus,
    input  CS_ADDRESS_SEQUENCER_RD_In,
    input  CS_ADDRESS_SEQUENCER_WR_In,
    input  CS_ADDRESS_SEQUENCER_MemReady_In,
    input  CS_ADDRESS_SEQUENCER_FlagEn_In,
    input  CS_ADDRESS_SEQUENCER_NZVC_InBus,
    output CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
    output CS_ADDRESS_SEQUENCER_PSR_OutBus,
    output CS_ADDRESS_SEQUENCER_Hold_Out
  );
endinterface

// File: rtl/cs_address_sequencer.sv
// Control-store address sequencer: picks the next microinstruction address
// (increment / flag branch / jump / opcode decode) and stalls on main memory.
module cs_address_sequencer #(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_IR          = 32
) (
  input logic                   CS_ADDRESS_SEQUENCER_CLOCK_50,
  input logic                   CS_ADDRESS_SEQUENCER_ResetInHigh_In,
  cs_address_sequencer_if.slave csBus
);

  typedef enum logic {RUN = 1'b0, WAIT_MEM = 1'b1} seqState_t;

  seqState_t                        state_p1, stateNext;
  logic [DATAWIDTH_JUMPADDRESS-1:0] csAddress_p1, addrNext;
  logic [3:0]                       psr_p1;
  logic                             psrLoad;

  logic [DATAWIDTH_JUMPADDRESS-1:0] addrInc, decodeAddr, selAddr;
  logic                             condTrue, memAccess;
  logic                             unusedIrBits;

  logic [DATAWIDTH_CONDITION-1:0]   condition;
  logic [DATAWIDTH_IR-1:0]          ir;

  assign condition = csBus.CS_ADDRESS_SEQUENCER_Condition_InBus;
  assign ir        = csBus.CS_ADDRESS_SEQUENCER_IR_InBus;

  assign addrInc    = csAddress_p1 + DATAWIDTH_JUMPADDRESS'(1);
  // Opcode dispatch table lives in the upper half of the control store.
  assign decodeAddr = DATAWIDTH_JUMPADDRESS'({1'b1, ir[31:30], ir[24:19], 2'b00});
  assign memAccess  = csBus.CS_ADDRESS_SEQUENCER_RD_In | csBus.CS_ADDRESS_SEQUENCER_WR_In;
  assign unusedIrBits = ^{ir[29:25], ir[18:14], ir[12:0]};

  // Flag tests read the latched PSR, never the live ALU flags.
  always_comb begin
    condTrue = 1'b0;
    selAddr  = addrInc;
    case (condition)
      3'b001: condTrue = psr_p1[3];
      3'b010: condTrue = psr_p1[2];
      3'b011: condTrue = psr_p1[1];
      3'b100: condTrue = psr_p1[0];
      3'b101: condTrue = ir[13];
      default: condTrue = 1'b0;
    endcase
    case (condition)
      3'b000:  selAddr = addrInc;
      3'b110:  selAddr = csBus.CS_ADDRESS_SEQUENCER_JumpAddress_InBus;
      3'b111:  selAddr = decodeAddr;
      default: selAddr = condTrue ? csBus.CS_ADDRESS_SEQUENCER_JumpAddress_InBus : addrInc;
    endcase
  end

  always_comb begin
    stateNext = state_p1;
    addrNext  = csAddress_p1;
    psrLoad   = 1'b0;
    unique case (state_p1)
      RUN: begin
        psrLoad = csBus.CS_ADDRESS_SEQUENCER_FlagEn_In;
        if (memAccess && !csBus.CS_ADDRESS_SEQUENCER_MemReady_In) begin
          stateNext = WAIT_MEM;
        end else begin
          addrNext = selAddr;
        end
      end
      WAIT_MEM: begin
        if (csBus.CS_ADDRESS_SEQUENCER_MemReady_In) begin
          stateNext = RUN;
          addrNext  = selAddr;
          psrLoad   = csBus.CS_ADDRESS_SEQUENCER_FlagEn_In;
        end
      end
    endcase
  end

  // Stage p1: registered address, PSR and sequencer state
  always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50 or posedge CS_ADDRESS_SEQUENCER_ResetInHigh_In) begin
    if (CS_ADDRESS_SEQUENCER_ResetInHigh_In) begin
      state_p1     <= RUN;
      csAddress_p1 <= '0;
      psr_p1       <= 4'b0000;
    end else begin
      state_p1     <= stateNext;
      csAddress_p1 <= addrNext;
      if (psrLoad) begin
        psr_p1 <= csBus.CS_ADDRESS_SEQUENCER_NZVC_InBus;
      end
    end
  end

  assign csBus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus = csAddress_p1;
  assign csBus.CS_ADDRESS_SEQUENCER_PSR_OutBus       = psr_p1;
  assign csBus.CS_ADDRESS_SEQUENCER_Hold_Out         = (state_p1 == WAIT_MEM);

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Directed bench for cs_address_sequencer with hand-computed expected values.
module tb_cs_address_sequencer;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  cs_address_sequencer_if #(.DATAWIDTH_JUMPADDRESS(11), .DATAWIDTH_CONDITION(3), .DATAWIDTH_IR(32)) bus ();

  cs_address_sequencer #(.DATAWIDTH_JUMPADDRESS(11), .DATAWIDTH_CONDITION(3), .DATAWIDTH_IR(32)) dut (
    .CS_ADDRESS_SEQUENCER_CLOCK_50      (clk),
    .CS_ADDRESS_SEQUENCER_ResetInHigh_In(rst),
    .csBus                              (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setFields(input logic [2:0] cond, input logic [10:0] jump);
    bus.CS_ADDRESS_SEQUENCER_Condition_InBus   = cond;
    bus.CS_ADDRESS_SEQUENCER_JumpAddress_InBus = jump;
  endtask

  function automatic logic [31:0] addr();
    return 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus);
  endfunction

  function automatic logic [31:0] hold();
    return 32'(bus.CS_ADDRESS_SEQUENCER_Hold_Out);
  endfunction

  function automatic logic [31:0] psr();
    return 32'(bus.CS_ADDRESS_SEQUENCER_PSR_OutBus);
  endfunction

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst = 1'b1;
    setFields(3'b000, 11'd0);
    bus.CS_ADDRESS_SEQUENCER_IR_InBus    = 32'h0;
    bus.CS_ADDRESS_SEQUENCER_RD_In       = 1'b0;
    bus.CS_ADDRESS_SEQUENCER_WR_In       = 1'b0;
    bus.CS_ADDRESS_SEQUENCER_MemReady_In = 1'b0;
    bus.CS_ADDRESS_SEQUENCER_FlagEn_In   = 1'b0;
    bus.CS_ADDRESS_SEQUENCER_NZVC_InBus  = 4'b0000;
    #12;
    check("reset_addr", addr(), 0);
    check("reset_psr", psr(), 0);
    check("reset_hold", hold(), 0);
    rst = 1'b0;

    // Sequential increment
    tick(); check("inc1", addr(), 1);
    tick(); check("inc2", addr(), 2);
    tick(); check("inc3", addr(), 3); check("inc_hold", hold(), 0);

    // Decode: {1, IR[31:30], IR[24:19], 00}
    bus.CS_ADDRESS_SEQUENCER_IR_InBus = 32'h8080_0000; setFields(3'b111, 11'd5);
    tick(); check("decode_op10", addr(), 1600);
    bus.CS_ADDRESS_SEQUENCER_IR_InBus = 32'h0080_0000;
    tick(); check("decode_op00", addr(), 1088);
    bus.CS_ADDRESS_SEQUENCER_IR_InBus = 32'h8100_0000;
    tick(); check("decode_81000000", addr(), 1664);

    // Load Z=1 and branch on it
    bus.CS_ADDRESS_SEQUENCER_IR_InBus = 32'h0;
    bus.CS_ADDRESS_SEQUENCER_FlagEn_In = 1'b1; bus.CS_ADDRESS_SEQUENCER_NZVC_InBus = 4'b0100;
    setFields(3'b000, 11'd0);
    tick(); check("flagload_addr", addr(), 1665); check("flagload_psr", psr(), 4'b0100);
    bus.CS_ADDRESS_SEQUENCER_FlagEn_In = 1'b0;
    setFields(3'b010, 11'd1604);
    tick(); check("z_taken", addr(), 1604);
    // FlagEn coinciding with a test: branch sees old Z=1
    bus.CS_ADDRESS_SEQUENCER_FlagEn_In = 1'b1; bus.CS_ADDRESS_SEQUENCER_NZVC_InBus = 4'b0000;
    setFields(3'b010, 11'd100);
    tick(); check("z_old_psr", addr(), 100); check("psr_cleared", psr(), 0);
    bus.CS_ADDRESS_SEQUENCER_FlagEn_In = 1'b0;
    setFields(3'b010, 11'd200);
    tick(); check("z_not_taken", addr(), 101);

    // N, V, C and IR[13] tests
    bus.CS_ADDRESS_SEQUENCER_FlagEn_In = 1'b1; bus.CS_ADDRESS_SEQUENCER_NZVC_InBus = 4'b1011;
    setFields(3'b000, 11'd0);
    tick(); check("psr_1011", psr(), 4'b1011); check("psr_1011_addr", addr(), 102);
    bus.CS_ADDRESS_SEQUENCER_FlagEn_In = 1'b0; bus.CS_ADDRESS_SEQUENCER_NZVC_InBus = 4'b0100;
    setFields(3'b001, 11'd300); tick(); check("n_taken", addr(), 300);
    setFields(3'b011, 11'd400); tick(); check("v_taken", addr(), 400);
    setFields(3'b100, 11'd500); tick(); check("c_taken", addr(), 500);
    setFields(3'b010, 11'd600); tick(); check("z_live_ignored", addr(), 501);
    bus.CS_ADDRESS_SEQUENCER_IR_InBus = 32'h0000_2000;
    setFields(3'b101, 11'd700); tick(); check("ir13_taken", addr(), 700);
    bus.CS_ADDRESS_SEQUENCER_IR_InBus = 32'h0;
    setFields(3'b101, 11'd800); tick(); check("ir13_not_taken", addr(), 701);

    // Memory stall: three frozen cycles then advance
    setFields(3'b000, 11'd0);
    bus.CS_ADDRESS_SEQUENCER_RD_In = 1'b1; bus.CS_ADDRESS_SEQUENCER_MemReady_In = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall_addr", addr(), 701); check("stall_hold", hold(), 1);
    end
    bus.CS_ADDRESS_SEQUENCER_MemReady_In = 1'b1;
    tick(); check("stall_release_addr", addr(), 702); check("stall_release_hold", hold(), 0);
    tick(); check("rd_ready_addr", addr(), 703); check("rd_ready_hold", hold(), 0);
    bus.CS_ADDRESS_SEQUENCER_WR_In = 1'b1;
    tick(); check("rdwr_ready_addr", addr(), 704); check("rdwr_ready_hold", hold(), 0);

    // PSR must not load while stalled, but loads on the releasing edge
    bus.CS_ADDRESS_SEQUENCER_WR_In = 1'b0; bus.CS_ADDRESS_SEQUENCER_MemReady_In = 1'b0;
    tick(); check("wait2_hold", hold(), 1);
    bus.CS_ADDRESS_SEQUENCER_FlagEn_In = 1'b1; bus.CS_ADDRESS_SEQUENCER_NZVC_InBus = 4'b0100;
    tick(); check("wait_psr_held", psr(), 4'b1011); check("wait_addr_held", addr(), 704);
    bus.CS_ADDRESS_SEQUENCER_MemReady_In = 1'b1;
    setFields(3'b010, 11'd900);
    tick(); check("release_old_psr", addr(), 705); check("release_psr_load", psr(), 4'b0100);
    check("release_hold", hold(), 0);

    // Wrap and unconditional jump
    bus.CS_ADDRESS_SEQUENCER_RD_In = 1'b0; bus.CS_ADDRESS_SEQUENCER_FlagEn_In = 1'b0;
    setFields(3'b110, 11'd2047); tick(); check("jump_2047", addr(), 2047);
    setFields(3'b000, 11'd0);    tick(); check("wrap", addr(), 0);
    setFields(3'b110, 11'd1603); tick(); check("jump_1603", addr(), 1603);

    // Asynchronous reset in the middle of a stall
    setFields(3'b000, 11'd0);
    bus.CS_ADDRESS_SEQUENCER_RD_In = 1'b1; bus.CS_ADDRESS_SEQUENCER_MemReady_In = 1'b0;
    tick(); check("pre_reset_hold", hold(), 1); check("pre_reset_addr", addr(), 1603);
    #2 rst = 1'b1;
    #1;
    check("async_reset_addr", addr(), 0);
    check("async_reset_hold", hold(), 0);
    check("async_reset_psr", psr(), 0);
    bus.CS_ADDRESS_SEQUENCER_RD_In = 1'b0;
    #2 rst = 1'b0;
    check("post_release_addr", addr(), 0);
    tick(); check("first_edge_after_reset", addr(), 1); check("first_edge_hold", hold(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
